// File: rtl/bcd_updown_counter_7seg.sv
// Multi-digit BCD up/down counter fed by two debounced, edge-detected switches; registered active-low 7-seg per digit.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits on o_Segments only.
module bcd_updown_counter_7seg #(
  parameter int NUM_DIGITS     = 2,
  parameter int MAX_COUNT      = 99,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic                      i_Switch_Up,
  input  logic                      i_Switch_Down,
  output logic [4*NUM_DIGITS-1:0]   o_Count,
  output logic                      o_Wrap,
  output logic [7*NUM_DIGITS-1:0]   o_Segments
);

  localparam int CW = 4*NUM_DIGITS;
  localparam int SW = 7*NUM_DIGITS;
  localparam int DW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_LIMIT - 1);

  function automatic logic [CW-1:0] to_bcd(input int value);
    int v;
    v = value;
    to_bcd = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      to_bcd[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

  localparam logic [CW-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [1:0]    w_raw;
  logic [DW-1:0] r_db_cnt [2];
  logic [1:0]    r_stable;
  logic [1:0]    r_prev;
  logic [1:0]    r_press;
  logic [CW-1:0] r_count;
  logic          r_wrap;
  logic [SW-1:0] r_seg;
  logic [CW-1:0] w_inc;
  logic [CW-1:0] w_dec;
  logic [CW-1:0] w_next_count;
  logic          w_next_wrap;
  logic [SW-1:0] w_seg;

  assign w_raw = {i_Switch_Down, i_Switch_Up};

  // Bit 0 is the up switch, bit 1 the down switch.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
      r_stable    <= '0;
      r_prev      <= '0;
      r_press     <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_raw[s] == r_stable[s]) begin
          r_db_cnt[s] <= '0;
        end else if (r_db_cnt[s] == DB_LAST) begin
          r_stable[s] <= w_raw[s];
          r_db_cnt[s] <= '0;
        end else begin
          r_db_cnt[s] <= r_db_cnt[s] + DW'(1);
        end
      end
      r_prev  <= r_stable;
      r_press <= r_stable & ~r_prev;
    end
  end

  always_comb begin : p_arith
    logic carry;
    logic borrow;
    w_inc  = r_count;
    w_dec  = r_count;
    carry  = 1'b1;
    borrow = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (r_count[4*k +: 4] == 4'd9) begin
          w_inc[4*k +: 4] = 4'd0;
        end else begin
          w_inc[4*k +: 4] = r_count[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (r_count[4*k +: 4] == 4'd0) begin
          w_dec[4*k +: 4] = 4'd9;
        end else begin
          w_dec[4*k +: 4] = r_count[4*k +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_next_count = r_count;
    w_next_wrap  = 1'b0;
    case (r_press)
      2'b01: begin
        if (r_count == MAX_BCD) begin
          w_next_count = '0;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_count = w_inc;
        end
      end
      2'b10: begin
        if (r_count == '0) begin
          w_next_count = MAX_BCD;
          w_next_wrap  = 1'b1;
        end else begin
          w_next_count = w_dec;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_wrap  <= w_next_wrap;
    end
  end

  // Scan from the most significant digit; digit 0 always shows its glyph.
  always_comb begin : p_decode
    logic lead;
    w_seg = '0;
    lead  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_seg[7*k +: 7] = seg7(r_count[4*k +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && lead && r_count[4*k +: 4] == 4'd0) begin
        w_seg[7*k +: 7] = 7'b1111111;
      end else begin
        lead = 1'b0;
      end
`else
      lead = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_seg <= {NUM_DIGITS{7'b0000001}};
    end else begin
      r_seg <= w_seg;
    end
  end

  assign o_Count    = r_count;
  assign o_Wrap     = r_wrap;
  assign o_Segments = r_seg;

endmodule
